// File: rtl/lsc_i2cs_16_pkg.sv
// Shared definitions for the lsc_i2cs_16 I2C target: FSM state encoding,
// bus-level ACK/NACK constants and small state-class helpers.
package lsc_i2cs_16_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEV     = 4'd1,
    S_ACK_DEV = 4'd2,
    S_OFS_HI  = 4'd3,
    S_ACK_HI  = 4'd4,
    S_OFS_LO  = 4'd5,
    S_ACK_LO  = 4'd6,
    S_WDAT    = 4'd7,
    S_ACK_WD  = 4'd8,
    S_RDAT    = 4'd9,
    S_MACK    = 4'd10,
    S_IGNORE  = 4'd11
  } state_t;

  // SDA levels as seen on the wire; NACK doubles as "released".
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // States in which the target shifts in a byte from the master.
  function automatic logic is_rx_state(input state_t s);
    return (s == S_DEV) || (s == S_OFS_HI) || (s == S_OFS_LO) || (s == S_WDAT);
  endfunction

  // States in which the target owns the 9th-bit ACK slot.
  function automatic logic is_ack_state(input state_t s);
    return (s == S_ACK_DEV) || (s == S_ACK_HI) || (s == S_ACK_LO) || (s == S_ACK_WD);
  endfunction

endpackage

// File: rtl/lsc_i2cs_16_filt.sv
// Bus input conditioner for the I2C target: 2-FF synchroniser and a
// stability filter on both SCL and SDA, followed by edge and START/STOP
// detection on the filtered levels.
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   scl_in, sda_in     raw bus levels
//   sda_f              filtered SDA level
//   scl_rise/scl_fall  one-clk pulses on filtered SCL edges
//   start_det          one-clk pulse: SDA fell while SCL high
//   stop_det           one-clk pulse: SDA rose while SCL high
module lsc_i2cs_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int CNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  // bit 1 = SCL, bit 0 = SDA throughout
  logic [1:0]            line_p0;
  logic [1:0]            line_p1;
  logic [1:0]            filt_p2;
  logic [1:0]            prev_p3;
  logic [1:0][CNT_W-1:0] cnt_q;

  // stage p0/p1: synchroniser, idles at bus-released level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_p0 <= 2'b11;
      line_p1 <= 2'b11;
    end else begin
      line_p0 <= {scl_in, sda_in};
      line_p1 <= line_p0;
    end
  end

  // stage p2: filtered level follows only after FILT_LEN consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_p2 <= 2'b11;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (line_p1[i] == filt_p2[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
          filt_p2[i] <= line_p1[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // stage p3: previous filtered level for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_p3 <= 2'b11;
    end else begin
      prev_p3 <= filt_p2;
    end
  end

  assign sda_f     = filt_p2[0];
  assign scl_rise  =  filt_p2[1] & ~prev_p3[1];
  assign scl_fall  = ~filt_p2[1] &  prev_p3[1];
  // SCL must be high both before and after the SDA edge
  assign start_det = filt_p2[1] & prev_p3[1] &  prev_p3[0] & ~filt_p2[0];
  assign stop_det  = filt_p2[1] & prev_p3[1] & ~prev_p3[0] &  filt_p2[0];

endmodule

// File: rtl/lsc_i2cs_16.sv
// I2C target with 7-bit device address, 16-bit register offset and 8-bit
// data, bridged to a simple synchronous register port. The offset
// auto-increments per data byte in both directions (16-bit wrap).
// Ports:
//   clk, reset           system clock (>= 16x SCL), async active-high reset
//   scl_in, sda_in       bus levels
//   sda_out              0 = pull SDA low, 1 = release
//   scl_out              tied 1 (no clock stretching)
//   reg_addr             register pointer for the current access
//   reg_wdata, reg_we    write data and one-clk write strobe
//   reg_re, reg_rdata    one-clk read strobe; data captured 1 clk later
//   busy                 START..STOP, any address
//   selected             address matched, until STOP/START
module lsc_i2cs_16
  import lsc_i2cs_16_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h24,
  parameter int         FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  output logic        scl_out,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        selected
);

  logic       sda_f;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] bit_cnt;
  logic [6:0] rx_q;
  logic [7:0] rx_byte;
  logic [7:0] tx_q;
  logic [7:0] ofs_hi;
  logic       rw_q;
  logic       ack_drv;
  logic       byte_done;
  logic       addr_match;

  lsc_i2cs_filt #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign scl_out    = 1'b1;
  assign rx_byte    = {rx_q, sda_f};
  assign byte_done  = scl_rise && (bit_cnt == 4'd7);
  assign addr_match = (rx_byte[7:1] == DEV_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_DEV;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_DEV:     if (byte_done) state_d = addr_match ? S_ACK_DEV : S_IGNORE;
        S_OFS_HI:  if (byte_done) state_d = S_ACK_HI;
        S_OFS_LO:  if (byte_done) state_d = S_ACK_LO;
        S_WDAT:    if (byte_done) state_d = S_ACK_WD;
        // ack_drv marks the second SCL fall of the slot, which ends it
        S_ACK_DEV: if (scl_fall && ack_drv) state_d = rw_q ? S_RDAT : S_OFS_HI;
        S_ACK_HI:  if (scl_fall && ack_drv) state_d = S_OFS_LO;
        S_ACK_LO:  if (scl_fall && ack_drv) state_d = S_WDAT;
        S_ACK_WD:  if (scl_fall && ack_drv) state_d = S_WDAT;
        S_RDAT:    if (scl_fall && (bit_cnt == 4'd8)) state_d = S_MACK;
        S_MACK:    if (scl_rise) state_d = (sda_f == ACK) ? S_RDAT : S_IGNORE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_out   <= NACK;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      selected  <= 1'b0;
      bit_cnt   <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      ofs_hi    <= '0;
      rw_q      <= 1'b0;
      ack_drv   <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      // post-write increment lands the clk after the strobe
      if (reg_we) reg_addr <= reg_addr + 16'd1;
      if (reg_re) tx_q <= reg_rdata;

      if (start_det || stop_det) begin
        sda_out  <= NACK;
        busy     <= start_det;
        selected <= 1'b0;
        bit_cnt  <= '0;
        ack_drv  <= 1'b0;
      end else begin
        case (state_q)
          S_DEV, S_OFS_HI, S_OFS_LO, S_WDAT: begin
            if (scl_rise) begin
              rx_q    <= rx_byte[6:0];
              bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
            end
            if (byte_done) begin
              case (state_q)
                S_DEV: begin
                  if (addr_match) begin
                    selected <= 1'b1;
                    rw_q     <= rx_byte[0];
                    reg_re   <= rx_byte[0];
                  end
                end
                S_OFS_HI: ofs_hi   <= rx_byte;
                S_OFS_LO: reg_addr <= {ofs_hi, rx_byte};
                default: begin
                  reg_wdata <= rx_byte;
                  reg_we    <= 1'b1;
                end
              endcase
            end
          end
          S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_WD: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_out <= ACK;
                ack_drv <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                if ((state_q == S_ACK_DEV) && rw_q) begin
                  // the slot-ending fall already carries read bit 7
                  sda_out <= tx_q[7];
                  tx_q    <= {tx_q[6:0], 1'b1};
                  bit_cnt <= 4'd1;
                end else begin
                  sda_out <= NACK;
                  bit_cnt <= '0;
                end
              end
            end
          end
          S_RDAT: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_out <= NACK;
                bit_cnt <= '0;
              end else begin
                sda_out <= tx_q[7];
                tx_q    <= {tx_q[6:0], 1'b1};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_MACK: begin
            if (scl_rise && (sda_f == ACK)) begin
              reg_addr <= reg_addr + 16'd1;
              reg_re   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsc_i2cs_16.sv
module tb_lsc_i2cs_16;

  localparam int Q = 250;  // quarter SCL period in clk-period/10 units

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m;
  logic        sda_m;
  logic        sda_out;
  logic        scl_out;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic        busy;
  logic        selected;
  wire         sda_bus = sda_m & sda_out;

  int total = 0;
  int bad   = 0;

  lsc_i2cs_16 #(.DEV_ADDR(7'h24), .FILT_LEN(3)) dut (
    .clk       (clk),
    .reset     (rst),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_out   (sda_out),
    .scl_out   (scl_out),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .selected  (selected)
  );

  always #5 clk = ~clk;

  // register-file model and strobe logs
  logic [7:0]  mem [0:65535];
  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [15:0] re_addr_q[$];
  int          both_cnt    = 0;
  int          sda_low_cnt = 0;

  assign reg_rdata = mem[reg_addr];

  always @(posedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
      mem[reg_addr] <= reg_wdata;
    end
    if (reg_re) re_addr_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt <= both_cnt + 1;
    if (!sda_out) sda_low_cnt <= sda_low_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // ---------------- bus master primitives ----------------
  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  // gl_len > 0 injects a high pulse on SDA mid-high of bit 3 (needs b[3]=0)
  task automatic write_byte_g(input logic [7:0] b, input int gl_len, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1;
      if (i == 3 && gl_len > 0) begin
        #Q; sda_m = 1'b1; #(gl_len); sda_m = 1'b0; #(Q - gl_len);
      end else begin
        #(2*Q);
      end
      scl_m = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    ack = sda_bus; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    write_byte_g(b, 0, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl_m = 1'b1;
      #Q; b[i] = sda_bus;
      #Q; scl_m = 1'b0;
      #Q;
    end
    sda_m = mack; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  task automatic send_bytes(input string nm, input logic [7:0] bytes[$], input logic want);
    logic a;
    foreach (bytes[i]) begin
      write_byte(bytes[i], a);
      total++;
      if (a !== want) begin
        bad++;
        $display("FAIL %s_ack%0d got=%b want=%b", nm, i, a, want);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    #2 rst = 1'b1;
    #50;
    total++; if (sda_out !== 1'b1)    begin bad++; $display("FAIL rst_sda got=%b want=1", sda_out); end
    total++; if (scl_out !== 1'b1)    begin bad++; $display("FAIL rst_scl got=%b want=1", scl_out); end
    total++; if (reg_addr !== 16'h0)  begin bad++; $display("FAIL rst_addr got=%h want=0000", reg_addr); end
    total++; if (reg_wdata !== 8'h0)  begin bad++; $display("FAIL rst_wdata got=%h want=00", reg_wdata); end
    total++; if (reg_we !== 1'b0)     begin bad++; $display("FAIL rst_we got=%b want=0", reg_we); end
    total++; if (reg_re !== 1'b0)     begin bad++; $display("FAIL rst_re got=%b want=0", reg_re); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (selected !== 1'b0)   begin bad++; $display("FAIL rst_sel got=%b want=0", selected); end
    #50 rst = 1'b0;
    #(4*Q);
  endtask

  task automatic test_write();
    int b0 = we_addr_q.size();
    i2c_start();
    send_bytes("wr", '{8'h48, 8'h30, 8'h10, 8'hAB, 8'hCD}, 1'b0);
    total++; if (selected !== 1'b1) begin bad++; $display("FAIL wr_selected got=%b want=1", selected); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL wr_busy got=%b want=1", busy); end
    i2c_stop(); #Q;
    total++;
    if (we_addr_q.size() - b0 !== 2) begin
      bad++; $display("FAIL wr_we_count got=%0d want=2", we_addr_q.size() - b0);
    end else begin
      total++; if (we_addr_q[b0] !== 16'h3010)   begin bad++; $display("FAIL wr_we0_addr got=%h want=3010", we_addr_q[b0]); end
      total++; if (we_data_q[b0] !== 8'hAB)      begin bad++; $display("FAIL wr_we0_data got=%h want=ab", we_data_q[b0]); end
      total++; if (we_addr_q[b0+1] !== 16'h3011) begin bad++; $display("FAIL wr_we1_addr got=%h want=3011", we_addr_q[b0+1]); end
      total++; if (we_data_q[b0+1] !== 8'hCD)    begin bad++; $display("FAIL wr_we1_data got=%h want=cd", we_data_q[b0+1]); end
    end
    total++; if (reg_addr !== 16'h3012) begin bad++; $display("FAIL wr_end_addr got=%h want=3012", reg_addr); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL wr_busy_after_stop got=%b want=0", busy); end
    total++; if (selected !== 1'b0)     begin bad++; $display("FAIL wr_sel_after_stop got=%b want=0", selected); end
  endtask

  task automatic test_combined_read();
    int r0 = re_addr_q.size();
    int w0 = we_addr_q.size();
    logic a;
    logic [7:0] d0, d1;
    i2c_start();
    send_bytes("rdofs", '{8'h48, 8'h30, 8'h10}, 1'b0);
    i2c_start();
    write_byte(8'h49, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_dev_ack got=%b want=0", a); end
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop(); #Q;
    total++; if (d0 !== 8'hAB) begin bad++; $display("FAIL rd_byte0 got=%h want=ab", d0); end
    total++; if (d1 !== 8'hCD) begin bad++; $display("FAIL rd_byte1 got=%h want=cd", d1); end
    total++;
    if (re_addr_q.size() - r0 !== 2) begin
      bad++; $display("FAIL rd_re_count got=%0d want=2", re_addr_q.size() - r0);
    end else begin
      total++; if (re_addr_q[r0] !== 16'h3010)   begin bad++; $display("FAIL rd_re0_addr got=%h want=3010", re_addr_q[r0]); end
      total++; if (re_addr_q[r0+1] !== 16'h3011) begin bad++; $display("FAIL rd_re1_addr got=%h want=3011", re_addr_q[r0+1]); end
    end
    total++; if (we_addr_q.size() !== w0) begin bad++; $display("FAIL rd_no_we got=%0d want=%0d", we_addr_q.size(), w0); end
  endtask

  task automatic test_ignore();
    int w0 = we_addr_q.size();
    int r0 = re_addr_q.size();
    int l0 = sda_low_cnt;
    i2c_start();
    send_bytes("ign", '{8'h4A, 8'h12, 8'h34}, 1'b1);
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL ign_busy got=%b want=1", busy); end
    total++; if (selected !== 1'b0) begin bad++; $display("FAIL ign_selected got=%b want=0", selected); end
    i2c_stop(); #Q;
    total++; if (sda_low_cnt !== l0)       begin bad++; $display("FAIL ign_sda_low got=%0d want=%0d", sda_low_cnt, l0); end
    total++; if (we_addr_q.size() !== w0)  begin bad++; $display("FAIL ign_we got=%0d want=%0d", we_addr_q.size(), w0); end
    total++; if (re_addr_q.size() !== r0)  begin bad++; $display("FAIL ign_re got=%0d want=%0d", re_addr_q.size(), r0); end
    total++; if (busy !== 1'b0)            begin bad++; $display("FAIL ign_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_wrap();
    int b0 = we_addr_q.size();
    i2c_start();
    send_bytes("wrap", '{8'h48, 8'hFF, 8'hFF, 8'h11, 8'h22}, 1'b0);
    i2c_stop(); #Q;
    total++;
    if (we_addr_q.size() - b0 !== 2) begin
      bad++; $display("FAIL wrap_we_count got=%0d want=2", we_addr_q.size() - b0);
    end else begin
      total++; if (we_addr_q[b0] !== 16'hFFFF)   begin bad++; $display("FAIL wrap_we0_addr got=%h want=ffff", we_addr_q[b0]); end
      total++; if (we_addr_q[b0+1] !== 16'h0000) begin bad++; $display("FAIL wrap_we1_addr got=%h want=0000", we_addr_q[b0+1]); end
      total++; if (we_data_q[b0+1] !== 8'h22)    begin bad++; $display("FAIL wrap_we1_data got=%h want=22", we_data_q[b0+1]); end
    end
    total++; if (reg_addr !== 16'h0001) begin bad++; $display("FAIL wrap_end_addr got=%h want=0001", reg_addr); end
  endtask

  task automatic test_reset_mid();
    int b0;
    logic a;
    i2c_start();
    send_bytes("rmofs", '{8'h48, 8'h30, 8'h10}, 1'b0);
    i2c_start();
    write_byte(8'h49, a);
    // data 0xAB: bits 7..5 = 1,0,1 ; bit 4 = 0 held by the target
    sda_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
    #Q; scl_m = 1'b1; #Q;
    total++; if (sda_out !== 1'b0) begin bad++; $display("FAIL rm_bit4_driven got=%b want=0", sda_out); end
    rst = 1'b1; #1;
    total++; if (sda_out !== 1'b1) begin bad++; $display("FAIL rm_sda_released got=%b want=1", sda_out); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
    #20 rst = 1'b0;
    #(Q - 21);
    scl_m = 1'b0; #Q;
    i2c_stop(); #Q;
    b0 = we_addr_q.size();
    i2c_start();
    send_bytes("rmwr", '{8'h48, 8'h40, 8'h00, 8'h5A}, 1'b0);
    i2c_stop(); #Q;
    total++;
    if (we_addr_q.size() - b0 !== 1) begin
      bad++; $display("FAIL rm_we_count got=%0d want=1", we_addr_q.size() - b0);
    end else begin
      total++; if (we_addr_q[b0] !== 16'h4000) begin bad++; $display("FAIL rm_we_addr got=%h want=4000", we_addr_q[b0]); end
      total++; if (we_data_q[b0] !== 8'h5A)    begin bad++; $display("FAIL rm_we_data got=%h want=5a", we_data_q[b0]); end
    end
  endtask

  task automatic test_glitch();
    int b0;
    logic a;
    // 2-clk pulse: must be filtered, transfer continues
    b0 = we_addr_q.size();
    i2c_start();
    send_bytes("glofs", '{8'h48, 8'h50, 8'h00}, 1'b0);
    write_byte_g(8'h00, 20, a);
    total++; if (a !== 1'b0)    begin bad++; $display("FAIL gl2_ack got=%b want=0", a); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gl2_busy got=%b want=1", busy); end
    send_bytes("gl2", '{8'h77}, 1'b0);
    i2c_stop(); #Q;
    total++;
    if (we_addr_q.size() - b0 !== 2) begin
      bad++; $display("FAIL gl2_we_count got=%0d want=2", we_addr_q.size() - b0);
    end else begin
      total++; if (we_data_q[b0] !== 8'h00)      begin bad++; $display("FAIL gl2_we0_data got=%h want=00", we_data_q[b0]); end
      total++; if (we_addr_q[b0+1] !== 16'h5001) begin bad++; $display("FAIL gl2_we1_addr got=%h want=5001", we_addr_q[b0+1]); end
      total++; if (we_data_q[b0+1] !== 8'h77)    begin bad++; $display("FAIL gl2_we1_data got=%h want=77", we_data_q[b0+1]); end
    end
    // 5-clk pulse passes the filter: seen as STOP then START, byte lost
    b0 = we_addr_q.size();
    i2c_start();
    send_bytes("gl5ofs", '{8'h48, 8'h50, 8'h10}, 1'b0);
    write_byte_g(8'h00, 50, a);
    total++; if (a !== 1'b1)        begin bad++; $display("FAIL gl5_ack got=%b want=1", a); end
    total++; if (selected !== 1'b0) begin bad++; $display("FAIL gl5_selected got=%b want=0", selected); end
    i2c_stop(); #Q;
    total++; if (we_addr_q.size() !== b0) begin bad++; $display("FAIL gl5_we got=%0d want=%0d", we_addr_q.size(), b0); end
  endtask

  task automatic test_exclusive();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL we_re_overlap got=%0d want=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_combined_read();
    test_ignore();
    test_wrap();
    test_reset_mid();
    test_glitch();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
